// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and the default frame/oversample
// constants used by the transmitter, receiver and baud generator.
package uart_pkg;

  localparam int DEFAULT_DATA_WIDTH      = 8;
  localparam int DEFAULT_OVERSAMPLE_RATE = 16;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } rx_state_e;

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line; resets to the idle-high level.
module rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  // Two-stage capture of the line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: oversampled start detection, mid-bit sampling of an LSB-first word,
// and a one-cycle valid or framing-error pulse at the mid stop bit.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH      = DEFAULT_DATA_WIDTH,
  parameter int OVERSAMPLE_RATE = DEFAULT_OVERSAMPLE_RATE
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tick,
  input  logic                  rx_in,
  output logic [DATA_WIDTH-1:0] rx_out,
  output logic                  rx_dv,
  output logic                  frame_err,
  output logic                  rx_busy
);

  localparam int TCW = $clog2(OVERSAMPLE_RATE) + 1;
  localparam int BCW = $clog2(DATA_WIDTH) + 1;
  localparam logic [TCW-1:0] MID_CNT  = TCW'(OVERSAMPLE_RATE / 2 - 1);
  localparam logic [TCW-1:0] LAST_CNT = TCW'(OVERSAMPLE_RATE - 1);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH - 1);

  logic                  w_rx_s;
  rx_state_e             r_state,     w_state_nxt;
  logic [TCW-1:0]        r_tick_cnt,  w_tick_cnt_nxt;
  logic [BCW-1:0]        r_bit_cnt,   w_bit_cnt_nxt;
  logic [DATA_WIDTH-1:0] r_shift,     w_shift_nxt;
  logic [DATA_WIDTH-1:0] r_rx_out,    w_rx_out_nxt;
  logic                  r_rx_dv,     w_rx_dv_nxt;
  logic                  r_frame_err, w_frame_err_nxt;
  logic                  r_busy;

  rx_sync u_rx_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (rx_in),
    .o_sync  (w_rx_s)
  );

  // Next-state, counter, shift and output-pulse decode; everything advances only on tick
  always_comb begin
    w_state_nxt     = r_state;
    w_tick_cnt_nxt  = r_tick_cnt;
    w_bit_cnt_nxt   = r_bit_cnt;
    w_shift_nxt     = r_shift;
    w_rx_out_nxt    = r_rx_out;
    w_rx_dv_nxt     = 1'b0;
    w_frame_err_nxt = 1'b0;
    if (tick) begin
      case (r_state)
        IDLE: begin
          if (!w_rx_s) begin
            w_state_nxt    = START;
            w_tick_cnt_nxt = {TCW{1'b0}};
          end else begin
            w_state_nxt = IDLE;
          end
        end
        START: begin
          if (r_tick_cnt == MID_CNT) begin
            if (!w_rx_s) begin
              w_state_nxt    = DATA;
              w_tick_cnt_nxt = {TCW{1'b0}};
              w_bit_cnt_nxt  = {BCW{1'b0}};
            end else begin
              w_state_nxt = IDLE;
            end
          end else begin
            w_tick_cnt_nxt = r_tick_cnt + TCW'(1);
          end
        end
        DATA: begin
          if (r_tick_cnt == LAST_CNT) begin
            for (int i = 0; i < DATA_WIDTH; i++) begin
              w_shift_nxt[i] = (r_bit_cnt == BCW'(i)) ? w_rx_s : r_shift[i];
            end
            w_tick_cnt_nxt = {TCW{1'b0}};
            if (r_bit_cnt == LAST_BIT) begin
              w_state_nxt = STOP;
            end else begin
              w_bit_cnt_nxt = r_bit_cnt + BCW'(1);
            end
          end else begin
            w_tick_cnt_nxt = r_tick_cnt + TCW'(1);
          end
        end
        STOP: begin
          if (r_tick_cnt == LAST_CNT) begin
            w_tick_cnt_nxt = {TCW{1'b0}};
            if (w_rx_s) begin
              w_rx_out_nxt = r_shift;
              w_rx_dv_nxt  = 1'b1;
              w_state_nxt  = IDLE;
            end else begin
              w_frame_err_nxt = 1'b1;
              w_state_nxt     = WAIT_HIGH;
            end
          end else begin
            w_tick_cnt_nxt = r_tick_cnt + TCW'(1);
          end
        end
        WAIT_HIGH: begin
          // A held-low (break) line must not be mistaken for a new start bit
          if (w_rx_s) begin
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = WAIT_HIGH;
          end
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // State, counters, shift register and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_tick_cnt  <= {TCW{1'b0}};
      r_bit_cnt   <= {BCW{1'b0}};
      r_shift     <= {DATA_WIDTH{1'b0}};
      r_rx_out    <= {DATA_WIDTH{1'b0}};
      r_rx_dv     <= 1'b0;
      r_frame_err <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_tick_cnt  <= w_tick_cnt_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_shift     <= w_shift_nxt;
      r_rx_out    <= w_rx_out_nxt;
      r_rx_dv     <= w_rx_dv_nxt;
      r_frame_err <= w_frame_err_nxt;
      r_busy      <= (w_state_nxt != IDLE);
    end
  end

  assign rx_out    = r_rx_out;
  assign rx_dv     = r_rx_dv;
  assign frame_err = r_frame_err;
  assign rx_busy   = r_busy;

endmodule
